// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment display driver.
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } seg7_state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low {g,f,e,d,c,b,a} glyphs, index 15 ("F") first.
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment glyph.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_GLYPH[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Refresh strobe, tear-free value commit and anti-ghosting blanking for a 4-digit display.
// Define SEG7_LEADING_ZERO_BLANK_EN to suppress leading-zero digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 5000,
    parameter int unsigned BLANK_CYC   = 100
) (
    input  logic        clk_10MHz_i,
    input  logic        rst,
    input  logic        we_i,
    input  logic [15:0] wdata_i,
    input  logic [1:0]  digit_i,
    output logic        en_o,
    output logic        pending_o,
    output logic [3:0]  an_o,
    output logic [6:0]  seg_o
);

    localparam int unsigned PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int unsigned GW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(HALF_PERIOD - 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(BLANK_CYC - 1);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit LzBlank = 1'b1;
`else
    localparam bit LzBlank = 1'b0;
`endif

    logic [PW-1:0] pre_q, pre_d;
    logic          en_q, en_d;
    logic [15:0]   pend_q, pend_d;
    logic [15:0]   disp_q, disp_d;
    logic          pending_q, pending_d;
    logic [1:0]    prev_q;
    seg7_state_e   state_q;
    logic [GW-1:0] guard_q;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;

    logic          change;
    logic          commit;
    logic [3:0]    nibble;
    logic [3:0]    show_an;
    logic [6:0]    show_seg;

    assign change = (digit_i != prev_q);
    assign commit = (prev_q == 2'd3) && (digit_i == 2'd0);

    always_comb begin
        pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        en_d  = en_q ^ (pre_q == PRE_LAST);
    end

    // Commit takes the old pending value; a coincident write re-arms pending.
    always_comb begin
        disp_d    = disp_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        if (commit && pending_q) begin
            disp_d    = pend_q;
            pending_d = 1'b0;
        end
        if (we_i) begin
            pend_d    = wdata_i;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        unique case (digit_i)
            2'd0: nibble = disp_q[3:0];
            2'd1: nibble = disp_q[7:4];
            2'd2: nibble = disp_q[11:8];
            2'd3: nibble = disp_q[15:12];
        endcase
    end

    always_comb begin
        show_an = ~(4'b0001 << digit_i);
        if (LzBlank && (digit_i != 2'd0) && ((disp_q >> {digit_i, 2'b00}) == 16'h0)) begin
            show_an = AN_OFF;
        end
    end

    seg7_hex_decoder u_hex_decoder (
        .nibble_i (nibble),
        .seg_o    (show_seg)
    );

    always_ff @(posedge clk_10MHz_i) begin
        if (!rst) begin
            pre_q     <= '0;
            en_q      <= 1'b0;
            pend_q    <= 16'h0;
            disp_q    <= 16'h0;
            pending_q <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            en_q      <= en_d;
            pend_q    <= pend_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk_10MHz_i) begin
        if (!rst) begin
            state_q <= BLANK;
            guard_q <= GUARD_LOAD;
            prev_q  <= 2'd0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
        end else begin
            prev_q <= digit_i;
            if (change) begin
                state_q <= BLANK;
                guard_q <= GUARD_LOAD;
                an_q    <= AN_OFF;
                seg_q   <= SEG_OFF;
            end else begin
                unique case (state_q)
                    BLANK: begin
                        if (guard_q == '0) begin
                            state_q <= SHOW;
                            an_q    <= show_an;
                            seg_q   <= show_seg;
                        end else begin
                            guard_q <= guard_q - 1'b1;
                            an_q    <= AN_OFF;
                            seg_q   <= SEG_OFF;
                        end
                    end
                    SHOW: begin
                        an_q  <= show_an;
                        seg_q <= show_seg;
                    end
                endcase
            end
        end
    end

    assign en_o      = en_q;
    assign pending_o = pending_q;
    assign an_o      = an_q;
    assign seg_o     = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: a per-edge reference model queues expected outputs, a monitor compares them.
module tb_seg7_scan_driver;

    localparam int unsigned HP = 5000;
    localparam int unsigned BC = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [15:0] wdata = 16'h0;
    logic [1:0]  digit = 2'd0;
    logic        en;
    logic        pending;
    logic [3:0]  an;
    logic [6:0]  seg;

    seg7_scan_driver #(
        .HALF_PERIOD (HP),
        .BLANK_CYC   (BC)
    ) dut (
        .clk_10MHz_i (clk),
        .rst         (rst),
        .we_i        (we),
        .wdata_i     (wdata),
        .digit_i     (digit),
        .en_o        (en),
        .pending_o   (pending),
        .an_o        (an),
        .seg_o       (seg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       pend;
        logic       en;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endfunction

    // Reference model: counts edges since reset and since the last digit change.
    int          edges = 0;
    int          age = 0;
    logic [15:0] m_disp = 16'h0;
    logic [15:0] m_pend = 16'h0;
    logic        m_pending = 1'b0;
    logic [1:0]  m_prev = 2'd0;

    initial forever begin
        exp_t e;
        logic [3:0] nib;
        @(posedge clk);
        if (!rst) begin
            edges = 0; age = 0; m_disp = 16'h0; m_pend = 16'h0;
            m_pending = 1'b0; m_prev = 2'd0;
            e = '{an: 4'hF, seg: 7'h7F, pend: 1'b0, en: 1'b0};
        end else begin
            edges++;
            if (digit != m_prev) age = 0;
            else age++;
            if (age < BC) begin
                e.an  = 4'hF;
                e.seg = 7'h7F;
            end else begin
                nib   = m_disp[4*digit +: 4];
                e.an  = ~(4'b0001 << digit);
                e.seg = glyph[nib];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                if (digit != 0 && (m_disp >> (4*digit)) == 0) e.an = 4'hF;
`endif
            end
            if (m_prev == 2'd3 && digit == 2'd0 && m_pending) begin
                m_disp = m_pend;
                m_pending = 1'b0;
            end
            if (we) begin
                m_pend = wdata;
                m_pending = 1'b1;
            end
            m_prev = digit;
            e.pend = m_pending;
            e.en   = ((edges / HP) % 2) == 1;
        end
        q.push_back(e);
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("an_o", 32'(an), 32'(e.an));
            chk("seg_o", 32'(seg), 32'(e.seg));
            chk("pending_o", 32'(pending), 32'(e.pend));
            chk("en_o", 32'(en), 32'(e.en));
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(logic [15:0] v);
        we = 1'b1;
        wdata = v;
        cyc(1);
        we = 1'b0;
    endtask

    task automatic frame(int hold);
        for (int d = 0; d < 4; d++) begin
            digit = 2'(d);
            cyc(hold);
        end
    endtask

    initial begin
        cyc(3);
        rst = 1'b1;
        cyc(5010);

        // 0x1234 pending until the 3->0 wrap
        digit = 2'd1; cyc(150);
        wr(16'h1234);
        cyc(20);
        digit = 2'd2; cyc(150);
        digit = 2'd3; cyc(150);
        frame(150);
        frame(150);

        // Two writes in one frame: last wins
        digit = 2'd0; cyc(150);
        digit = 2'd1; cyc(20); wr(16'hAAAA); cyc(130);
        digit = 2'd2; cyc(20); wr(16'hBEEF); cyc(130);
        digit = 2'd3; cyc(150);
        frame(150);

        // Guard restart mid-blanking
        digit = 2'd1; cyc(50);
        digit = 2'd2; cyc(150);
        digit = 2'd3; cyc(150);

        // Write coincident with commit
        wr(16'h5678);
        cyc(50);
        we = 1'b1; wdata = 16'h9ABC; digit = 2'd0;
        cyc(1);
        we = 1'b0;
        cyc(150);
        digit = 2'd1; cyc(150);
        digit = 2'd2; cyc(150);
        digit = 2'd3; cyc(150);
        frame(150);

        // Leading zeros
        wr(16'h0050);
        frame(150);
        frame(150);

        // Reset mid-guard with a pending write
        wr(16'hFFFF);
        digit = 2'd1; cyc(20);
        rst = 1'b0; cyc(2);
        rst = 1'b1; cyc(200);
        frame(150);

        // Randomised traffic
        repeat (80) begin
            if ($urandom_range(0, 3) == 0) wr(16'($urandom));
            if ($urandom_range(0, 2) == 0) digit = 2'($urandom_range(0, 3));
            else digit = digit + 2'd1;
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b0; cyc(1); rst = 1'b1;
            end
            cyc($urandom_range(1, 250));
        end

        cyc(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Refresh-side controller for the 4-digit multiplexed 7-segment display peripheral. Generates the refresh strobe `en_o` consumed by the mod-4 digit counter, reads the counter's digit index back, and drives active-low anodes and segments. Holds a CPU-written 16-bit value with tear-free commit at frame boundaries and inserts a blanking guard on every digit change to suppress ghosting.

## Interface
Parameters:
- `HALF_PERIOD`, default 5000: clock cycles per `en_o` half-period. Default gives a 1 kHz digit rate and 250 Hz frame rate at 10 MHz.
- `BLANK_CYC`, default 100: anode-off guard cycles after each digit change; must be ≥1 and < 2·`HALF_PERIOD`.

Ports:
- `clk_10MHz_i`  in  1: system clock, 10 MHz.
- `rst`  in  1: reset, synchronous, active-low.
- `we_i`  in  1: single-cycle write strobe from the CPU bus.
- `wdata_i`  in  16: four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- `digit_i`  in  2: current digit index from the mod-4 counter.
- `en_o`  out  1: 50 % duty refresh square wave to the counter's enable.
- `pending_o`  out  1: a written value is waiting for frame commit.
- `an_o`  out  4: anodes, active-low, one-hot-low when showing.
- `seg_o`  out  7: segments {g,f,e,d,c,b,a}, active-low.

## Operation
- Prescaler: counts 0..`HALF_PERIOD`-1. At the terminal count it wraps to 0 and toggles `en_o`.
- Write path: `we_i`=1 loads `wdata_i` into `pend_r` and sets `pending_o`. A later write before commit overwrites `pend_r`; last write wins.
- Commit: when `digit_i` transitions 3→0, if `pending_o`=1 then `disp_r`←`pend_r` and `pending_o`←0.
  - If `we_i` arrives in the same cycle as commit, the old `pend_r` commits. The new data then loads `pend_r` and `pending_o` stays 1.
- Digit-change detect: `prev_r` registers `digit_i`. Any cycle with `digit_i`≠`prev_r` is a change event.
- FSM states: BLANK and SHOW.
  - BLANK: `an_o`=4'hF, `seg_o`=7'h7F. The guard counter counts down from `BLANK_CYC`-1; at 0 the FSM goes to SHOW.
  - SHOW: `an_o` is low only at bit `digit_i`, and `seg_o` = hex decode of `disp_r[4·digit_i+3 : 4·digit_i]`.
  - A change event in either state (re)enters BLANK with the guard counter reloaded.
- Decode: standard hex glyphs 0–F. A lit segment drives 0.

## Timing
- Reset values:
  - `en_o`=0, `pending_o`=0, `an_o`=4'hF, `seg_o`=7'h7F.
  - FSM=BLANK with guard=`BLANK_CYC`-1.
  - prescaler=0, `disp_r`=0, `pend_r`=0, `prev_r`=0.
- Reset is honoured on any cycle, including mid-guard and with a pending write; the pending write is discarded.
- First `en_o` rise occurs `HALF_PERIOD` cycles after `rst` deasserts.
- Outputs are registered; a change event at cycle N gives `an_o`=4'hF at N+1.
- SHOW is entered after `BLANK_CYC` cycles of blanking.
- `pending_o` rises the cycle after `we_i`. Commit is visible in `disp_r` the cycle after the 3→0 change event.

## Configuration
- `SEG7_LEADING_ZERO_BLANK_EN` defined: in SHOW, a digit whose nibble and all higher nibbles are 0 keeps its anode off (`an_o` bit stays 1). Digit 0 is always shown.
  - Example: 0x0050 lights digits 1 and 0 only.
- Not defined: all four digits are always shown, including leading zeros.

## Structure
- Shared package `seg7_pkg` holds:
  - the state enum `seg7_state_e` {BLANK, SHOW};
  - `SEG_OFF`=7'h7F and `AN_OFF`=4'hF;
  - the 16-entry hex glyph constant.
- Sub-module `seg7_hex_decoder` (4-bit nibble → 7-bit active-low segments, combinational) is instantiated once. The nibble mux stays in the top module.

## Test plan
- Reset, then idle with `digit_i` held at 0: `an_o`=4'hF for 100 cycles, then `an_o`=4'b1110, `seg_o`=glyph(0)=7'h40. First `en_o` rise occurs at cycle 5000.
- Write 0x1234 while `digit_i` cycles 0..3: `pending_o`=1 until a 3→0 transition. From the next frame digit 2 shows 7'h24 and digit 3 shows 7'h79.
- Two writes, 0xAAAA then 0xBEEF, in one frame: only 0xBEEF is ever displayed; digit 0 shows 7'h0E ("F").
- Change `digit_i` from 1 to 2 at 50 cycles into a guard: the guard restarts, giving 100 cycles of `an_o`=4'hF from the second change.
- `we_i` coincident with a 3→0 commit: the older value commits and `pending_o` stays 1. The new value displays one frame later.
- Write 0x0050 and, with the macro, check that anodes 3 and 2 stay off. Without the macro, digit 3 shows 7'h40.
